// File: rtl/fs_score_if.sv
// Handshake and data bundle between a corner-detector front end and the score engine.
// Signal names follow the engine's documented port list so waveforms read the same.
interface fs_score_if #(
  parameter int PIX_W  = 8,
  parameter int CIRCLE = 16,
  parameter int ADDR_W = 15
);
  logic                    inValid;
  logic                    inReady;
  logic                    isCorner;
  logic [ADDR_W-1:0]       refAddr;
  logic [PIX_W-1:0]        refPixel;
  logic [CIRCLE*PIX_W-1:0] adjPixel;
  logic [PIX_W-1:0]        thres;
  logic                    outValid;
  logic                    outReady;
  logic [ADDR_W-1:0]       outAddr;
  logic [PIX_W-1:0]        scoreValue;
  logic                    wren;

  modport master (
    output inValid, isCorner, refAddr, refPixel, adjPixel, thres, outReady,
    input  inReady, outValid, outAddr, scoreValue, wren
  );

  modport slave (
    input  inValid, isCorner, refAddr, refPixel, adjPixel, thres, outReady,
    output inReady, outValid, outAddr, scoreValue, wren
  );
endinterface

// File: rtl/fs_score_engine.sv
// FAST corner score: scans every start position of an ARC-long circular window and keeps the
// largest bright/dark minimum difference, one start per clock.
module fs_score_engine #(
  parameter int PIX_W  = 8,
  parameter int CIRCLE = 16,
  parameter int ARC    = 9,
  parameter int ADDR_W = 15
) (
  input logic      clk,
  input logic      rst_n,
  fs_score_if.slave bus
);
  localparam int SW = (CIRCLE > 1) ? $clog2(CIRCLE) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

  state_t            state_q;
  logic [SW-1:0]     s_q;
  logic [PIX_W-1:0]  best_q, best_d;
  logic [PIX_W-1:0]  ref_q, thres_q;
  logic [PIX_W-1:0]  adj_q [CIRCLE];
  logic [PIX_W-1:0]  adj_in [CIRCLE];
  logic [ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]  score_q;
  logic              in_ready_q, out_valid_q, wr_en_q;
  logic [PIX_W-1:0]  bright_k [ARC];
  logic [PIX_W-1:0]  dark_k [ARC];
  logic [PIX_W-1:0]  bright_min, dark_min;
  logic              best_gt;

  genvar gi;
  generate
    for (gi = 0; gi < CIRCLE; gi++) begin : g_unpack
      assign adj_in[gi] = bus.adjPixel[gi*PIX_W +: PIX_W];
    end

    for (gi = 0; gi < ARC; gi++) begin : g_arc
      logic [SW:0]      sum;
      logic [SW-1:0]    idx;
      logic [PIX_W-1:0] pix;
      assign sum = {1'b0, s_q} + (SW+1)'(gi);
      // Single conditional subtract is enough: s < CIRCLE and gi < CIRCLE.
      assign idx = (sum >= (SW+1)'(CIRCLE)) ? SW'(sum - (SW+1)'(CIRCLE)) : sum[SW-1:0];
      assign pix = adj_q[idx];
      assign bright_k[gi] = (pix > ref_q) ? pix - ref_q : '0;
      assign dark_k[gi]   = (ref_q > pix) ? ref_q - pix : '0;
    end
  endgenerate

  always_comb begin
    bright_min = '1;
    dark_min   = '1;
    for (int k = 0; k < ARC; k++) begin
      if (bright_k[k] < bright_min) bright_min = bright_k[k];
      if (dark_k[k] < dark_min)     dark_min   = dark_k[k];
    end
    best_d = best_q;
    if (bright_min > best_d) best_d = bright_min;
    if (dark_min > best_d)   best_d = dark_min;
    best_gt = (best_d > thres_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      best_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      score_q     <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.inValid) begin
            ref_q      <= bus.refPixel;
            adj_q      <= adj_in;
            thres_q    <= bus.thres;
            addr_q     <= bus.refAddr;
            best_q     <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b0;
            if (bus.isCorner) begin
              state_q <= SCAN;
            end else begin
              state_q     <= OUT;
              out_valid_q <= 1'b1;
              score_q     <= '0;
              wr_en_q     <= 1'b0;
            end
          end
        end
        SCAN: begin
          best_q <= best_d;
          s_q    <= s_q + SW'(1);
          if (s_q == SW'(CIRCLE - 1)) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            score_q     <= best_gt ? best_d : '0;
            wr_en_q     <= best_gt;
          end
        end
        OUT: begin
          if (bus.outReady) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            wr_en_q     <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.inReady    = in_ready_q;
  assign bus.outValid   = out_valid_q;
  assign bus.outAddr    = addr_q;
  assign bus.scoreValue = score_q;
  // Strobe must coincide with the handshake cycle itself, so it is gated by outReady.
  assign bus.wren       = out_valid_q & wr_en_q & bus.outReady;
endmodule

// File: tb/tb_fs_score_engine.sv
// Directed and random transactions against fs_score_engine; expected results go through a
// scoreboard queue and are compared when the engine presents outValid.
module tb_fs_score_engine;
  localparam int PIX_W  = 8;
  localparam int CIRCLE = 16;
  localparam int ARC    = 9;
  localparam int ADDR_W = 15;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  score;
    logic              wren;
    int                lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   wren_cnt = 0;
  exp_t sb [$];

  fs_score_if #(.PIX_W(PIX_W), .CIRCLE(CIRCLE), .ADDR_W(ADDR_W)) bus ();

  fs_score_engine #(.PIX_W(PIX_W), .CIRCLE(CIRCLE), .ARC(ARC), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.wren === 1'b1) wren_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] model_best(input logic [PIX_W-1:0] r,
                                                  input logic [CIRCLE*PIX_W-1:0] adj);
    int best = 0;
    for (int s = 0; s < CIRCLE; s++) begin
      int bm = 255;
      int dm = 255;
      for (int k = 0; k < ARC; k++) begin
        int p = int'(adj[((s + k) % CIRCLE)*PIX_W +: PIX_W]);
        int b = p - int'(r);
        int d = int'(r) - p;
        if (b < 0) b = 0;
        if (d < 0) d = 0;
        if (b < bm) bm = b;
        if (d < dm) dm = d;
      end
      if (bm > best) best = bm;
      if (dm > best) best = dm;
    end
    return PIX_W'(best);
  endfunction

  task automatic do_txn(input logic corner, input logic [ADDR_W-1:0] addr,
                        input logic [PIX_W-1:0] refp, input logic [CIRCLE*PIX_W-1:0] adj,
                        input logic [PIX_W-1:0] thr, input logic [PIX_W-1:0] exp_score,
                        input logic exp_wren, input int hold);
    exp_t e;
    int   n;
    int   w0;
    logic [PIX_W-1:0]  s_hold;
    logic [ADDR_W-1:0] a_hold;
    n = 0;
    while (bus.inReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", 32'(bus.inReady), 32'd1);
    bus.isCorner = corner;
    bus.refAddr  = addr;
    bus.refPixel = refp;
    bus.adjPixel = adj;
    bus.thres    = thr;
    bus.inValid  = 1'b1;
    bus.outReady = (hold == 0);
    e.addr  = addr;
    e.score = exp_score;
    e.wren  = exp_wren;
    e.lat   = corner ? CIRCLE + 1 : 1;
    sb.push_back(e);
    @(posedge clk);
    w0 = wren_cnt;
    #1;
    bus.inValid  = 1'b0;
    bus.isCorner = 1'($urandom);
    bus.refAddr  = ADDR_W'($urandom);
    bus.refPixel = PIX_W'($urandom);
    bus.thres    = PIX_W'($urandom);
    bus.adjPixel = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus.outValid === 1'b1) break;
    end
    e = sb.pop_front();
    check("latency", 32'(n), 32'(e.lat));
    check("score", 32'(bus.scoreValue), 32'(e.score));
    check("out_addr", 32'(bus.outAddr), 32'(e.addr));
    check("in_ready_busy", 32'(bus.inReady), 32'd0);
    if (hold > 0) begin
      s_hold = bus.scoreValue;
      a_hold = bus.outAddr;
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", 32'(bus.outValid), 32'd1);
        check("hold_score", 32'(bus.scoreValue), 32'(s_hold));
        check("hold_addr", 32'(bus.outAddr), 32'(a_hold));
        check("hold_in_ready", 32'(bus.inReady), 32'd0);
        check("hold_wren", 32'(bus.wren), 32'd0);
      end
      bus.outReady = 1'b1;
      #1;
    end
    check("wren_strobe", 32'(bus.wren), 32'(e.wren));
    @(negedge clk);
    check("wren_count", 32'(wren_cnt - w0), 32'(e.wren));
    check("in_ready_after", 32'(bus.inReady), 32'd1);
    check("out_valid_drop", 32'(bus.outValid), 32'd0);
    $display("txn addr=%0h corner=%0d score=%0d wren=%0d latency=%0d", addr, corner,
             bus.scoreValue, e.wren, n);
  endtask

  initial begin
    logic [CIRCLE*PIX_W-1:0] adj_v;
    logic [PIX_W-1:0]        r_v, t_v, b_v;
    int                      w0, ov;

    rst_n        = 1'b0;
    bus.inValid  = 1'b0;
    bus.isCorner = 1'b0;
    bus.refAddr  = '0;
    bus.refPixel = '0;
    bus.adjPixel = '0;
    bus.thres    = '0;
    bus.outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.outValid), 32'd0);
    check("rst_wren", 32'(bus.wren), 32'd0);
    check("rst_score", 32'(bus.scoreValue), 32'd0);
    check("rst_addr", 32'(bus.outAddr), 32'd0);
    check("rst_in_ready", 32'(bus.inReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Uniform bright circle
    for (int i = 0; i < CIRCLE; i++) adj_v[i*PIX_W +: PIX_W] = 8'd200;
    do_txn(1'b1, 15'h0011, 8'd100, adj_v, 8'd20, 8'd100, 1'b1, 0);

    // Single bright arc at indices 0..8, threshold below and at the score
    for (int i = 0; i < CIRCLE; i++) adj_v[i*PIX_W +: PIX_W] = (i < 9) ? 8'd130 : 8'd100;
    do_txn(1'b1, 15'h0022, 8'd100, adj_v, 8'd20, 8'd30, 1'b1, 0);
    do_txn(1'b1, 15'h0023, 8'd100, adj_v, 8'd30, 8'd0, 1'b0, 0);

    // Dark arc wrapping from index 12 through 4
    for (int i = 0; i < CIRCLE; i++)
      adj_v[i*PIX_W +: PIX_W] = (i >= 12 || i <= 4) ? 8'd60 : 8'd100;
    do_txn(1'b1, 15'h0033, 8'd100, adj_v, 8'd10, 8'd40, 1'b1, 0);

    // Non-corner bypass
    do_txn(1'b0, 15'h1234, 8'd100, adj_v, 8'd10, 8'd0, 1'b0, 0);

    // Backpressure on the uniform bright case
    for (int i = 0; i < CIRCLE; i++) adj_v[i*PIX_W +: PIX_W] = 8'd200;
    do_txn(1'b1, 15'h0044, 8'd100, adj_v, 8'd20, 8'd100, 1'b1, 5);

    // Random circles checked against the reference model
    for (int t = 0; t < 4; t++) begin
      r_v = PIX_W'($urandom_range(40, 200));
      for (int i = 0; i < CIRCLE; i++) adj_v[i*PIX_W +: PIX_W] = PIX_W'($urandom);
      if (t[0]) for (int i = 3; i < 3 + ARC; i++) adj_v[i*PIX_W +: PIX_W] = r_v - 8'd35;
      t_v = PIX_W'($urandom_range(0, 30));
      b_v = model_best(r_v, adj_v);
      do_txn(1'b1, ADDR_W'(16'h0100 + t), r_v, adj_v, t_v,
             (b_v > t_v) ? b_v : 8'd0, b_v > t_v, t);
    end

    // Reset in the middle of a scan discards the transaction
    for (int i = 0; i < CIRCLE; i++) adj_v[i*PIX_W +: PIX_W] = 8'd200;
    @(negedge clk);
    bus.isCorner = 1'b1;
    bus.refAddr  = 15'h0555;
    bus.refPixel = 8'd100;
    bus.adjPixel = adj_v;
    bus.thres    = 8'd20;
    bus.inValid  = 1'b1;
    bus.outReady = 1'b1;
    @(posedge clk);
    w0 = wren_cnt;
    #1;
    bus.inValid = 1'b0;
    ov = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.outValid === 1'b1) ov++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_in_ready", 32'(bus.inReady), 32'd1);
    check("mid_rst_score", 32'(bus.scoreValue), 32'd0);
    check("mid_rst_addr", 32'(bus.outAddr), 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(bus.inReady), 32'd1);
    repeat (25) begin
      @(negedge clk);
      if (bus.outValid === 1'b1) ov++;
    end
    check("mid_rst_no_valid", 32'(ov), 32'd0);
    check("mid_rst_no_wren", 32'(wren_cnt - w0), 32'd0);
    $display("txn addr=555 reset mid-scan outValid_seen=%0d wren_seen=%0d", ov, wren_cnt - w0);

    // Engine still works after the aborted transaction
    do_txn(1'b1, 15'h0066, 8'd100, adj_v, 8'd20, 8'd100, 1'b1, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
